// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: drives a PWM with a triangular "breathing" duty ramp.
// A start request latches the configuration. The duty then ramps lo->hi->lo
// with one duty step every step_time clocks. This repeats for `breaths` full
// breaths, or until stop when breaths is 0.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, stop         one-cycle sequence begin / abort requests
//   div_cfg             PWM divider, latched at start
//   duty_min, duty_max  duty bounds in percent, clamped to DUTY_CAP
//   step_time           clocks per duty step (0 treated as 1)
//   breaths             breath count, 0 = run until stop
//   pwm_en/div/duty     registered PWM controls
//   busy, done          active indicator and completion pulse
module pwm_ramp_ctrl #(
  parameter int unsigned DUTY_CAP = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] div_cfg,
  input  logic [6:0]  duty_min,
  input  logic [6:0]  duty_max,
  input  logic [15:0] step_time,
  input  logic [7:0]  breaths,
  output logic        pwm_en,
  output logic [15:0] pwm_div,
  output logic [6:0]  pwm_duty,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DivW  = 16;
  localparam int unsigned DutyW = 7;
  localparam int unsigned StepW = 16;
  localparam int unsigned CntW  = 8;

  // Cap saturated to what the duty port can represent.
  localparam logic [DutyW-1:0] CapDuty =
    (DUTY_CAP > 127) ? DutyW'(127) : DutyW'(DUTY_CAP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [StepW-1:0]  timer_q, timer_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   breaths_q, breaths_d;
  logic [DutyW-1:0]  hi_q, hi_d;
  logic [DutyW-1:0]  lo_q, lo_d;
  logic              pwm_en_q, pwm_en_d;
  logic [DivW-1:0]   pwm_div_q, pwm_div_d;
  logic [DutyW-1:0]  pwm_duty_q, pwm_duty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DutyW-1:0]  hi_cfg;
  logic [DutyW-1:0]  lo_cfg;
  logic              tick;
  logic [StepW-1:0]  timer_nxt;
  logic [CntW-1:0]   count_inc;

  // Bounds derived from live inputs; only used at the start handshake.
  assign hi_cfg = (duty_max > CapDuty) ? CapDuty : duty_max;
  assign lo_cfg = (duty_min > hi_cfg) ? hi_cfg : duty_min;

  // Step timer runs 0..step-1; tick on the last count.
  assign tick      = (timer_q == (step_q - StepW'(1)));
  assign timer_nxt = tick ? '0 : (timer_q + StepW'(1));
  assign count_inc = count_q + CntW'(1);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    step_d     = step_q;
    count_d    = count_q;
    breaths_d  = breaths_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pwm_en_d   = pwm_en_q;
    pwm_div_d  = pwm_div_q;
    pwm_duty_d = pwm_duty_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // stop wins over a simultaneous start.
        if (start && !stop) begin
          state_d    = UP;
          pwm_div_d  = div_cfg;
          breaths_d  = breaths;
          step_d     = (step_time == '0) ? StepW'(1) : step_time;
          hi_d       = hi_cfg;
          lo_d       = lo_cfg;
          pwm_en_d   = 1'b1;
          pwm_duty_d = lo_cfg;
          timer_d    = '0;
          count_d    = '0;
          busy_d     = 1'b1;
        end
      end

      UP: begin
        if (stop) begin
          state_d    = IDLE;
          pwm_en_d   = 1'b0;
          pwm_duty_d = '0;
          busy_d     = 1'b0;
          timer_d    = '0;
        end else begin
          timer_d = timer_nxt;
          if (tick) begin
            if (pwm_duty_q < hi_q) begin
              pwm_duty_d = pwm_duty_q + DutyW'(1);
            end else begin
              state_d = DOWN;
            end
          end
        end
      end

      DOWN: begin
        if (stop) begin
          state_d    = IDLE;
          pwm_en_d   = 1'b0;
          pwm_duty_d = '0;
          busy_d     = 1'b0;
          timer_d    = '0;
        end else begin
          timer_d = timer_nxt;
          if (tick) begin
            if (pwm_duty_q > lo_q) begin
              pwm_duty_d = pwm_duty_q - DutyW'(1);
            end else begin
              // Breath complete; the count wraps freely when breaths is 0.
              count_d = count_inc;
              if ((breaths_q != '0) && (count_inc == breaths_q)) begin
                state_d    = FINISH;
                pwm_en_d   = 1'b0;
                pwm_duty_d = '0;
                done_d     = 1'b1;
                timer_d    = '0;
              end else begin
                state_d = UP;
              end
            end
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        pwm_en_d   = 1'b0;
        pwm_duty_d = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      step_q     <= '0;
      count_q    <= '0;
      breaths_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pwm_en_q   <= 1'b0;
      pwm_div_q  <= '0;
      pwm_duty_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      step_q     <= step_d;
      count_q    <= count_d;
      breaths_q  <= breaths_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pwm_en_q   <= pwm_en_d;
      pwm_div_q  <= pwm_div_d;
      pwm_duty_q <= pwm_duty_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pwm_en   = pwm_en_q;
  assign pwm_div  = pwm_div_q;
  assign pwm_duty = pwm_duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_CAP, default 100: maximum legal duty value in percent.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a breathing sequence.
REQ-005 SHALL have port stop  input  1  one-cycle request to abort a running sequence.
REQ-006 SHALL have port div_cfg  input  16  clock divider value passed to the PWM.
REQ-007 SHALL have port duty_min  input  7  lower duty bound, percent.
REQ-008 SHALL have port duty_max  input  7  upper duty bound, percent.
REQ-009 SHALL have port step_time  input  16  clk cycles per duty step.
REQ-010 SHALL have port breaths  input  8  number of full breaths; 0 means run until stop.
REQ-011 SHALL have port pwm_en  output  1  enable driven to the PWM.
REQ-012 SHALL have port pwm_div  output  16  divider driven to the PWM.
REQ-013 SHALL have port pwm_duty  output  7  duty driven to the PWM.
REQ-014 SHALL have port busy  output  1  high in any active state.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement FSM states IDLE, UP, DOWN, FINISH; all outputs registered.
REQ-017 SHALL, in IDLE on start=1 and stop=0, latch div_cfg, breaths, step_time (0 stored as 1), hi=min(duty_max,DUTY_CAP), lo=min(duty_min,hi), and enter UP next cycle.
REQ-018 SHALL ignore configuration input changes while busy; latched values only.
REQ-019 SHALL, on the first UP cycle, present pwm_en=1, pwm_div=latched div, pwm_duty=lo, step timer=0, breath count=0.
REQ-020 SHALL count step timer 0..step-1 and assert an internal tick when timer==step-1, then wrap to 0.
REQ-021 SHALL, in UP on tick: if duty<hi, duty+1; else go to DOWN, duty unchanged.
REQ-022 SHALL, in DOWN on tick: if duty>lo, duty-1; else breath complete: count+1, go to FINISH if breaths!=0 and count+1==breaths, otherwise go to UP.
REQ-023 SHALL give one breath = 2*(hi-lo)+2 ticks; lo==hi gives 2 ticks with constant duty.
REQ-024 SHALL wrap breath count modulo 256 when breaths=0, with no effect on operation.
REQ-025 SHALL, in FINISH, drive pwm_en=0, pwm_duty=0, done=1 for exactly one cycle, then enter IDLE.
REQ-026 SHALL, on stop=1 in UP or DOWN, enter IDLE next cycle with pwm_en=0, pwm_duty=0, busy=0, and no done pulse.
REQ-027 SHALL ignore start while busy; stop in IDLE has no effect; start and stop together in IDLE: stop wins, stay IDLE.
REQ-028 SHALL hold pwm_div at its last value in IDLE; pwm_en=0 and pwm_duty=0 in IDLE.
REQ-029 SHALL keep busy=1 in UP, DOWN, FINISH; 0 in IDLE.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set state IDLE, pwm_en=0, pwm_div=0, pwm_duty=0, busy=0, done=0, timer=0, count=0.
REQ-031 SHALL give rst priority over start and stop, and abort any sequence mid-operation without a done pulse.

Verification
REQ-032 SHALL cover: lo=10, hi=90, step=100, breaths=1, start -> duty climbs 10..90 one per 100 cycles, reverses, done pulse 16200 cycles after first UP cycle, pwm_en=0 after.
REQ-033 SHALL cover: duty_max=120, duty_min=110, step=1, breaths=2 -> hi=lo=100, duty constant 100, done after 4 ticks.
REQ-034 SHALL cover: step_time=0, lo=0, hi=3, breaths=1 -> behaves as step=1, duty sequence 0,1,2,3,3,2,1,0,0, then done.
REQ-035 SHALL cover: breaths=0, stop after 5000 cycles -> next cycle pwm_en=0, pwm_duty=0, busy=0, done never asserted.
REQ-036 SHALL cover: second start mid-sequence and input changes while busy -> no effect on waveform; start+stop together in IDLE -> remains IDLE.
REQ-037 SHALL cover: rst=1 mid-DOWN -> next cycle all outputs zero, state IDLE; new start then runs normally.
